// File: rtl/booth_mult_arbiter_pkg.sv
// Shared constants and the tag record that follows each operation through the multiplier.
package booth_mult_arbiter_pkg;

  localparam int NREQ    = 2;
  localparam int ID_W    = 1;
  localparam int DEF_N   = 32;
  localparam int DEF_LAT = 2;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/booth_tag_pipe.sv
// LAT-deep {vld,id} shift register that mirrors the multiplier's enabled registers.
module booth_tag_pipe
  import booth_mult_arbiter_pkg::*;
#(
  parameter int LAT = DEF_LAT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            in_vld_i,
  input  logic [ID_W-1:0] in_id_i,
  output logic            out_vld_o,
  output logic [ID_W-1:0] out_id_o,
  output logic            any_vld_o
);

  tag_t tag_q [LAT];

  // Shift tags one stage per enabled cycle; hold when the multiplier is frozen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else if (en_i) begin
      tag_q[0] <= {in_vld_i, in_id_i};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Report whether any operation is still travelling through the multiplier.
  always_comb begin
    any_vld_o = 1'b0;
    for (int i = 0; i < LAT; i++) any_vld_o = any_vld_o | tag_q[i].vld;
  end

  assign out_vld_o = tag_q[LAT-1].vld;
  assign out_id_o  = tag_q[LAT-1].id;

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin sharing of one pipelined multiplier between two requesters, with
// per-requester result holding registers and a global stall when a result has nowhere to go.
module booth_mult_arbiter
  import booth_mult_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int LAT = DEF_LAT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s0_valid,
  output logic           s0_ready,
  input  logic [N-1:0]   s0_a,
  input  logic [N-1:0]   s0_b,
  input  logic           s1_valid,
  output logic           s1_ready,
  input  logic [N-1:0]   s1_a,
  input  logic [N-1:0]   s1_b,
  output logic           r0_valid,
  input  logic           r0_ready,
  output logic [2*N-1:0] r0_result,
  output logic           r1_valid,
  input  logic           r1_ready,
  output logic [2*N-1:0] r1_result,
  output logic           mul_en,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_result,
  output logic           idle
);

  logic            out_vld;
  logic [ID_W-1:0] out_id;
  logic            any_vld;
  logic            stall;
  logic            issue;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] last_q, last_d;
  logic            fill0, fill1;
  logic            r0_valid_q, r0_valid_d, r1_valid_q, r1_valid_d;
  logic [2*N-1:0]  r0_result_q, r0_result_d, r1_result_q, r1_result_d;

  booth_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk_i     (clk),
    .rst_ni    (reset),
    .en_i      (mul_en),
    .in_vld_i  (issue),
    .in_id_i   (grant_id),
    .out_vld_o (out_vld),
    .out_id_o  (out_id),
    .any_vld_o (any_vld)
  );

  // Freeze everything when the completing product's destination is full and not draining.
  always_comb begin
    stall = 1'b0;
    if (out_vld) begin
      if (out_id == 1'b1) stall = r1_valid_q && !r1_ready;
      else                stall = r0_valid_q && !r0_ready;
    end
  end

  assign mul_en = !stall && reset;

  // Round-robin grant: on a tie the requester not granted last wins.
  always_comb begin
    issue = s0_valid || s1_valid;
    if (s0_valid && s1_valid) grant_id = ~last_q;
    else                      grant_id = ~s0_valid;
    last_d = (mul_en && issue) ? grant_id : last_q;
  end

  assign s0_ready = mul_en && (grant_id == 1'b0) && s0_valid;
  assign s1_ready = mul_en && (grant_id == 1'b1) && s1_valid;

  // Route the granted operands to the multiplier; zero when nobody is asking.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (issue) begin
      mul_a = (grant_id == 1'b1) ? s1_a : s0_a;
      mul_b = (grant_id == 1'b1) ? s1_b : s0_b;
    end
  end

  // Result holding registers: a fill on the same edge as a drain keeps valid high.
  always_comb begin
    fill0       = mul_en && out_vld && (out_id == 1'b0);
    fill1       = mul_en && out_vld && (out_id == 1'b1);
    r0_valid_d  = fill0 || (r0_valid_q && !r0_ready);
    r1_valid_d  = fill1 || (r1_valid_q && !r1_ready);
    r0_result_d = fill0 ? mul_result : r0_result_q;
    r1_result_d = fill1 ? mul_result : r1_result_q;
  end

  // Register pointer and result state; reset drops everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q      <= 1'b1;
      r0_valid_q  <= 1'b0;
      r1_valid_q  <= 1'b0;
      r0_result_q <= '0;
      r1_result_q <= '0;
    end else begin
      last_q      <= last_d;
      r0_valid_q  <= r0_valid_d;
      r1_valid_q  <= r1_valid_d;
      r0_result_q <= r0_result_d;
      r1_result_q <= r1_result_d;
    end
  end

  assign r0_valid  = r0_valid_q;
  assign r1_valid  = r1_valid_q;
  assign r0_result = r0_result_q;
  assign r1_result = r1_result_q;
  assign idle      = !any_vld && !r0_valid_q && !r1_valid_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a two-register multiplier attached on mul_*.
module tb_booth_mult_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [31:0] s0_a = '0, s0_b = '0, s1_a = '0, s1_b = '0;
  logic        r0_valid, r1_valid;
  logic        r0_ready = 1'b0, r1_ready = 1'b0;
  logic [63:0] r0_result, r1_result;
  logic        mul_en;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        idle;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  booth_mult_arbiter #(.N(32), .LAT(2)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_a(s0_a), .s0_b(s0_b),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_a(s1_a), .s1_b(s1_b),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_result(r0_result),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_result(r1_result),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .idle(idle)
  );

  // Shared multiplier: input register then product register, both on mul_en, same reset net.
  logic signed [31:0] ma_q, mb_q;
  logic signed [63:0] mp_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma_q <= '0;
      mb_q <= '0;
      mp_q <= '0;
    end else if (mul_en) begin
      ma_q <= mul_a;
      mb_q <= mul_b;
      mp_q <= ma_q * mb_q;
    end
  end
  assign mul_result = mp_q;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_a = 32'd1; s0_b = 32'd1;
    #1;
    total++; if (s0_ready !== 1'b0) begin bad++; $display("FAIL rst_s0_ready: got %b want 0", s0_ready); end
    total++; if (mul_en !== 1'b0) begin bad++; $display("FAIL rst_mul_en: got %b want 0", mul_en); end
    total++; if (r0_valid !== 1'b0 || r1_valid !== 1'b0) begin bad++; $display("FAIL rst_valids: got %b%b want 00", r0_valid, r1_valid); end
    total++; if (r0_result !== 64'd0 || r1_result !== 64'd0) begin bad++; $display("FAIL rst_results: got %h %h want 0 0", r0_result, r1_result); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", idle); end
    s0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (mul_en !== 1'b1) begin bad++; $display("FAIL rst_release_en: got %b want 1", mul_en); end
  endtask

  task automatic test_tie();
    r0_ready = 1'b1; r1_ready = 1'b1;
    s0_a = 32'd2; s0_b = 32'd3; s1_a = 32'd4; s1_b = 32'd5;
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      s0_valid = (j < 8); s1_valid = (j < 8);
      #1;
      if (j < 8) begin
        total++; if (s0_ready !== (j % 2 == 0)) begin bad++; $display("FAIL tie_s0_ready[%0d]: got %b want %b", j, s0_ready, (j % 2 == 0)); end
        total++; if (s1_ready !== (j % 2 == 1)) begin bad++; $display("FAIL tie_s1_ready[%0d]: got %b want %b", j, s1_ready, (j % 2 == 1)); end
      end
      if (j >= 3) begin
        if ((j - 3) % 2 == 0) begin
          total++; if (r0_valid !== 1'b1 || r1_valid !== 1'b0 || r0_result !== 64'd6) begin bad++; $display("FAIL tie_r0[%0d]: got v=%b%b res=%h want v=10 res=6", j, r0_valid, r1_valid, r0_result); end
        end else begin
          total++; if (r1_valid !== 1'b1 || r0_valid !== 1'b0 || r1_result !== 64'd20) begin bad++; $display("FAIL tie_r1[%0d]: got v=%b%b res=%h want v=01 res=20", j, r0_valid, r1_valid, r1_result); end
        end
      end
    end
    @(negedge clk);
    #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL tie_idle: got %b want 1", idle); end
  endtask

  task automatic test_single();
    @(negedge clk);
    s0_valid = 1'b1; s0_a = 32'd7; s0_b = -32'sd3; r0_ready = 1'b1;
    #1;
    total++; if (s0_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", s0_ready); end
    @(negedge clk);
    s0_valid = 1'b0;
    #1;
    total++; if (s0_ready !== 1'b0 || r0_valid !== 1'b0) begin bad++; $display("FAIL single_c1: got rdy=%b v=%b want 0 0", s0_ready, r0_valid); end
    @(negedge clk); #1;
    total++; if (r0_valid !== 1'b0) begin bad++; $display("FAIL single_c2: got v=%b want 0", r0_valid); end
    @(negedge clk); #1;
    total++; if (r0_valid !== 1'b1 || r0_result !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL single_result: got v=%b res=%h want v=1 res=ffffffffffffffeb", r0_valid, r0_result); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", idle); end
    @(negedge clk); #1;
    total++; if (r0_valid !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL single_done: got v=%b idle=%b want 0 1", r0_valid, idle); end
  endtask

  task automatic test_backpressure();
    r0_ready = 1'b1; r1_ready = 1'b0;
    @(negedge clk);
    s1_valid = 1'b1; s1_a = 32'd3; s1_b = 32'd3;
    #1;
    total++; if (s1_ready !== 1'b1) begin bad++; $display("FAIL bp_issue1: got %b want 1", s1_ready); end
    @(negedge clk);
    s1_a = 32'd2; s1_b = 32'd2;
    #1;
    total++; if (s1_ready !== 1'b1) begin bad++; $display("FAIL bp_issue2: got %b want 1", s1_ready); end
    @(negedge clk);
    s1_valid = 1'b0;
    for (int c = 3; c < 5; c++) begin
      @(negedge clk);
      s0_valid = 1'b1; s0_a = 32'd6; s0_b = 32'd7;
      #1;
      total++; if (mul_en !== 1'b0 || s0_ready !== 1'b0) begin bad++; $display("FAIL bp_stall[%0d]: got en=%b rdy=%b want 0 0", c, mul_en, s0_ready); end
      total++; if (r1_valid !== 1'b1 || r1_result !== 64'd9) begin bad++; $display("FAIL bp_hold[%0d]: got v=%b res=%h want 1 9", c, r1_valid, r1_result); end
    end
    @(negedge clk);
    r1_ready = 1'b1;
    #1;
    total++; if (mul_en !== 1'b1 || s0_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got en=%b rdy=%b want 1 1", mul_en, s0_ready); end
    total++; if (r1_valid !== 1'b1 || r1_result !== 64'd9) begin bad++; $display("FAIL bp_first: got v=%b res=%h want 1 9", r1_valid, r1_result); end
    @(negedge clk);
    s0_valid = 1'b0;
    #1;
    total++; if (r1_valid !== 1'b1 || r1_result !== 64'd4) begin bad++; $display("FAIL bp_second: got v=%b res=%h want 1 4", r1_valid, r1_result); end
    @(negedge clk); #1;
    total++; if (r1_valid !== 1'b0 || r0_valid !== 1'b0) begin bad++; $display("FAIL bp_gap: got v=%b%b want 00", r0_valid, r1_valid); end
    @(negedge clk); #1;
    total++; if (r0_valid !== 1'b1 || r0_result !== 64'd42) begin bad++; $display("FAIL bp_other: got v=%b res=%h want 1 42", r0_valid, r0_result); end
    @(negedge clk); #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL bp_idle: got %b want 1", idle); end
  endtask

  task automatic test_fill_drain();
    r0_ready = 1'b1;
    for (int d = 0; d < 7; d++) begin
      @(negedge clk);
      s0_valid = (d < 3); s0_a = d + 1; s0_b = d + 1;
      #1;
      if (d < 3) begin
        total++; if (s0_ready !== 1'b1) begin bad++; $display("FAIL fd_ready[%0d]: got %b want 1", d, s0_ready); end
      end else if (d < 6) begin
        total++; if (r0_valid !== 1'b1 || r0_result !== 64'((d - 2) * (d - 2))) begin bad++; $display("FAIL fd_result[%0d]: got v=%b res=%h want 1 %0d", d, r0_valid, r0_result, (d - 2) * (d - 2)); end
      end else begin
        total++; if (r0_valid !== 1'b0) begin bad++; $display("FAIL fd_end: got %b want 0", r0_valid); end
      end
    end
  endtask

  task automatic test_mid_reset();
    r0_ready = 1'b1;
    @(negedge clk);
    s0_valid = 1'b1; s0_a = 32'd8; s0_b = 32'd8;
    @(negedge clk);
    s0_a = 32'd9; s0_b = 32'd9;
    @(negedge clk);
    s0_valid = 1'b0;
    #1;
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL mr_inflight: got idle=%b want 0", idle); end
    #2 reset = 1'b0;
    #1;
    total++; if (mul_en !== 1'b0 || r0_valid !== 1'b0 || r1_valid !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL mr_assert: got en=%b v=%b%b idle=%b want 0 00 1", mul_en, r0_valid, r1_valid, idle); end
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk); #1;
      total++; if (r0_valid !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL mr_stale[%0d]: got v=%b idle=%b want 0 1", e, r0_valid, idle); end
    end
    @(negedge clk);
    s0_valid = 1'b1; s0_a = 32'd5; s0_b = 32'd5;
    @(negedge clk);
    s0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    total++; if (r0_valid !== 1'b1 || r0_result !== 64'd25) begin bad++; $display("FAIL mr_after: got v=%b res=%h want 1 25", r0_valid, r0_result); end
  endtask

  task automatic test_extremes();
    r1_ready = 1'b1;
    @(negedge clk);
    s1_valid = 1'b1; s1_a = 32'h8000_0000; s1_b = 32'h8000_0000;
    #1;
    total++; if (s1_ready !== 1'b1) begin bad++; $display("FAIL ext_ready: got %b want 1", s1_ready); end
    @(negedge clk);
    s1_a = 32'h7FFF_FFFF; s1_b = 32'hFFFF_FFFF;
    @(negedge clk);
    s1_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (r1_valid !== 1'b1 || r1_result !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL ext_minmin: got v=%b res=%h want 1 4000000000000000", r1_valid, r1_result); end
    @(negedge clk); #1;
    total++; if (r1_valid !== 1'b1 || r1_result !== 64'hFFFF_FFFF_8000_0001) begin bad++; $display("FAIL ext_maxneg1: got v=%b res=%h want 1 ffffffff80000001", r1_valid, r1_result); end
    @(negedge clk); #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL ext_idle: got %b want 1", idle); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_backpressure();
    test_fill_drain();
    test_mid_reset();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
Shares one registered radix-4 Booth multiplier (N-bit signed operands, 2N-bit product, LAT-cycle pipeline with a single global enable) between two requesters. It does round-robin issue with valid/ready handshakes and carries a requester tag alongside each operation. When a product arrives it is routed into that requester's result holding register. It stalls the whole multiplier pipeline through the enable when a completing product has no free destination, so no result is ever dropped.

Parameters:
N, 32, operand width; product width 2N
LAT, 2, multiplier latency in enabled cycles (input register plus output register)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (reset=0 resets)
s0_valid  in  1  requester 0 operands valid
s0_ready  out  1  requester 0 operands accepted this cycle
s0_a, s0_b  in  N  requester 0 operands
s1_valid, s1_ready, s1_a, s1_b  as above, requester 1
r0_valid  out  1  requester 0 result valid
r0_ready  in  1  requester 0 consumes result
r0_result  out  2N  requester 0 product
r1_valid, r1_ready, r1_result  as above, requester 1
mul_en  out  1  global enable to the multiplier's registers
mul_a, mul_b  out  N  operands to the multiplier
mul_result  in  2N  multiplier output register
idle  out  1  no op in flight and both result registers empty

Behaviour:
- Tag pipeline: LAT stages of {vld, id}, mirroring the multiplier's registers. When stage LAT-1 is valid, mul_result holds that op's product.
- Stall rule:
  - stall = tag[LAT-1].vld && r_k_valid && !r_k_ready, where k = tag[LAT-1].id.
  - mul_en = !stall && reset.
  - When mul_en=0, the tag pipeline and grant pointer hold.
- Arbitration: round-robin over s0/s1.
  - One valid requester is granted.
  - If both are valid, the one not granted last wins.
  - The last-granted pointer resets to 1, so s0 wins the first tie.
- Ready signals: s_k_ready = mul_en && grant==k && s_k_valid. Combinational, no dependency on s_k_ready from the requester side.
- Operand drive: mul_a/mul_b = granted requester's operands; 0 when no grant.
- On each clk edge with mul_en=1:
  - tag[0] <= {issue, grant_id}, and tag[i] <= tag[i-1].
  - If tag[LAT-1].vld, then r_k_result <= mul_result and r_k_valid <= 1.
- Result drain: r_k_valid clears on r_k_ready, unless refilled on the same edge (fill and drain in one cycle is legal, valid stays 1).
- Throughput and latency:
  - One issue per cycle when not stalled.
  - Accept at edge t, no stalls: r_k_valid rises after edge t+LAT. The product is visible in the cycle following edge t+LAT.
- Ordering: results to a given requester are delivered in issue order. Interleaving across requesters follows issue order.
- Stall effect: the stall blocks all issue, including to the non-blocked requester. A requester holding r_k_ready=0 therefore stops the shared unit. This is intended; no per-requester buffering.
- idle = no tag vld && !r0_valid && !r1_valid.
- Reset (async assert, sync deassert by the top level):
  - All tag vld, r0_valid, r1_valid = 0; results = 0; pointer = 1.
  - s_k_ready = 0 and mul_en = 0 while reset is low.
  - Mid-operation reset drops all in-flight ops. The multiplier must be reset by the same net.
- Signed arithmetic is the multiplier's concern; this block passes products through unmodified.

Decomposition:
- Shared package constants: NREQ=2, requester ID width (1), default N/LAT, tag struct {vld, id}.
- One natural sub-module: booth_tag_pipe, a LAT-deep {vld,id} shift register with enable and async active-low reset.
- The arbiter, stall logic and result registers stay in the top module. The multiplier is instantiated by the parent and connected via mul_*.

Test Plan:
- Single op: s0 a=7, b=-3, r0_ready=1. s0_ready pulses once; r0_valid rises after edge t+2 with r0_result=-21 (64-bit sign-extended); idle returns to 1.
- Tie: s0 (a=2, b=3) and s1 (a=4, b=5) valid every cycle. Grants alternate s0, s1, s0, …; r0 sees 6, r1 sees 20 alternately; throughput 1/cycle.
- Back-pressure: r1_ready=0 with two s1 ops (3×3, then 2×2) issued. First fills r1 (9); second reaches stage LAT-1 → mul_en=0 and s0_ready=0. Raising r1_ready releases: 9 then 4, with no loss or duplication.
- Fill+drain same cycle: r0_ready=1 constant, back-to-back s0 ops 1×1, 2×2, 3×3. r0_valid stays high 3 cycles with 1, 4, 9.
- Mid-op reset: assert reset low with 2 ops in flight. All valids and mul_en go 0 immediately. After release, idle=1 and no stale result appears; the next s0 op 5×5 returns 25.
- Extremes: s1 a=-2^31, b=-2^31 → 2^62; a=2^31-1, b=-1 → -(2^31-1).
